// File: rtl/snn_setup_loader_pkg.sv
// Shared setup codes, opcode and state encodings for the SNN setup loader.
package snn_setup_loader_pkg;

  localparam logic [2:0] SETUP_INPUTS  = 3'b000;
  localparam logic [2:0] SETUP_WEIGHTS = 3'b001;
  localparam logic [2:0] SETUP_BN      = 3'b110;
  localparam logic [2:0] SETUP_THRESH  = 3'b011;
  localparam logic [2:0] CTRL_IDLE     = 3'b100;
  localparam logic [2:0] CTRL_UNUSED   = 3'b010;

  typedef enum logic { OP_LOAD = 1'b0, OP_RUN = 1'b1 } op_e;

  typedef enum logic [1:0] { ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2 } state_e;

  // Codes 100 and 010 select no core register, so bytes aimed there are
  // swallowed without touching the pins.
  function automatic logic is_live_code(logic [2:0] code);
    return !(code == CTRL_IDLE || code == CTRL_UNUSED);
  endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// One saturating spike counter with synchronous clear and count enable.
module snn_spike_counter
  import snn_setup_loader_pkg::*;
#(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/snn_setup_loader.sv
// Sequences LOAD/RUN commands onto the SNN core setup/execute pins and counts
// output spikes during RUN.
module snn_setup_loader
  import snn_setup_loader_pkg::*;
#(
  parameter int RUN_BITS = 16,
  parameter int CNT_BITS = 8,
  parameter int NUM_OUT  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [2:0]                   cmd_target,
  input  logic [RUN_BITS-1:0]          cmd_arg,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic [7:0]                   snn_data,
  output logic [2:0]                   snn_ctrl,
  output logic                         snn_sync,
  output logic                         snn_execute,
  input  logic [NUM_OUT-1:0]           snn_spikes,
  output logic [NUM_OUT*CNT_BITS-1:0]  spike_counts,
  output logic                         cnt_valid,
  output logic                         busy
);

  state_e              state_q, state_d;
  logic [2:0]          target_q, target_d;
  logic [RUN_BITS-1:0] rem_q, rem_d;
  logic [7:0]          data_q, data_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                sync_q, sync_d;
  logic                exec_q, exec_d;
  logic                cnt_valid_q, cnt_valid_d;
  logic                cnt_clr;

  // Next-state and next-pin logic; pins default to the non-matching idle code
  // so the core never shifts on a cycle without a fresh byte.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    rem_d       = rem_q;
    data_d      = data_q;
    ctrl_d      = CTRL_IDLE;
    sync_d      = 1'b0;
    exec_d      = 1'b0;
    cnt_valid_d = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          rem_d    = cmd_arg;
          if (op_e'(cmd_op) == OP_RUN) begin
            cnt_clr = 1'b1;
            if (cmd_arg == '0) begin
              cnt_valid_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              exec_d  = 1'b1;
            end
          end else if (cmd_arg != '0) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          rem_d = rem_q - 1'b1;
          if (is_live_code(target_q)) begin
            data_d = in_data;
            ctrl_d = target_q;
            sync_d = 1'b1;
          end
          if (rem_q == RUN_BITS'(1)) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // exec_q is already high for this cycle; drop it after the last one.
        rem_d = rem_q - 1'b1;
        if (rem_q == RUN_BITS'(1)) begin
          state_d     = ST_IDLE;
          cnt_valid_d = 1'b1;
        end else begin
          exec_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      target_q    <= CTRL_IDLE;
      rem_q       <= '0;
      data_q      <= '0;
      ctrl_q      <= CTRL_IDLE;
      sync_q      <= 1'b0;
      exec_q      <= 1'b0;
      cnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      sync_q      <= sync_d;
      exec_q      <= exec_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  // Spikes count only on cycles where the execute pin itself is high.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    snn_spike_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (exec_q & snn_spikes[i]),
      .count (spike_counts[i*CNT_BITS +: CNT_BITS])
    );
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign snn_data    = data_q;
  assign snn_ctrl    = ctrl_q;
  assign snn_sync    = sync_q;
  assign snn_execute = exec_q;
  assign cnt_valid   = cnt_valid_q;

endmodule

// File: tb/tb_snn_setup_loader.sv
// Scoreboard bench for snn_setup_loader: stimulus pushes expected pin bytes and
// run results; a negedge monitor pops and compares them.
module tb_snn_setup_loader;
  import snn_setup_loader_pkg::*;

  localparam int RUN_BITS = 16;
  localparam int CNT_BITS = 8;
  localparam int NUM_OUT  = 8;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        cmd_valid = 1'b0;
  logic                        cmd_ready;
  logic                        cmd_op = 1'b0;
  logic [2:0]                  cmd_target = 3'b000;
  logic [RUN_BITS-1:0]         cmd_arg = '0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [7:0]                  in_data = 8'h00;
  logic [7:0]                  snn_data;
  logic [2:0]                  snn_ctrl;
  logic                        snn_sync;
  logic                        snn_execute;
  logic [NUM_OUT-1:0]          snn_spikes = '0;
  logic [NUM_OUT*CNT_BITS-1:0] spike_counts;
  logic                        cnt_valid;
  logic                        busy;

  snn_setup_loader #(.RUN_BITS(RUN_BITS), .CNT_BITS(CNT_BITS), .NUM_OUT(NUM_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_target(cmd_target), .cmd_arg(cmd_arg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .snn_data(snn_data), .snn_ctrl(snn_ctrl), .snn_sync(snn_sync),
    .snn_execute(snn_execute), .snn_spikes(snn_spikes),
    .spike_counts(spike_counts), .cnt_valid(cnt_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] ctrl; logic [7:0] data; } pin_t;
  typedef struct { int cycles; logic [NUM_OUT*CNT_BITS-1:0] counts; } run_t;

  pin_t pin_q[$];
  run_t run_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exec_cnt = 0;
  int   ctrl_active = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every sync strobe and every cnt_valid pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (snn_execute) exec_cnt++;
      if (snn_ctrl != CTRL_IDLE) ctrl_active++;
      if (snn_sync) begin
        if (pin_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_sync: ctrl=%0b data=0x%0h", snn_ctrl, snn_data);
        end else begin
          pin_t e;
          e = pin_q.pop_front();
          chk("pin_ctrl", 64'(snn_ctrl), 64'(e.ctrl));
          chk("pin_data", 64'(snn_data), 64'(e.data));
        end
      end
      if (cnt_valid) begin
        if (run_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_cnt_valid: counts=0x%0h", spike_counts);
        end else begin
          run_t r;
          r = run_q.pop_front();
          chk("run_exec_cycles", 64'(exec_cnt), 64'(r.cycles));
          chk("run_counts", 64'(spike_counts), 64'(r.counts));
          chk("cmd_ready_at_cnt_valid", 64'(cmd_ready), 64'd1);
        end
        exec_cnt = 0;
      end
    end
  end

  task automatic issue_cmd(input logic op, input logic [2:0] tgt, input int arg);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt; cmd_arg = RUN_BITS'(arg);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin tests++; fails++; $display("FAIL cmd_ready_timeout: got 0 expected 1"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Caller is at posedge+1; optional idle gap cycles precede the byte.
  task automatic send_byte(input logic [2:0] tgt, input logic [7:0] d, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin tests++; fails++; $display("FAIL in_ready_timeout: got 0 expected 1"); end
    if (is_live_code(tgt)) pin_q.push_back('{ctrl: tgt, data: d});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin tests++; fails++; $display("FAIL busy_timeout: got 1 expected 0"); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_OUT*CNT_BITS-1:0] exp_counts(input logic [NUM_OUT-1:0] pat, input int n);
    logic [NUM_OUT*CNT_BITS-1:0] v;
    int s;
    s = (n > 255) ? 255 : n;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) if (pat[i]) v[i*CNT_BITS +: CNT_BITS] = CNT_BITS'(s);
    return v;
  endfunction

  task automatic do_run(input logic [NUM_OUT-1:0] pat, input int n);
    snn_spikes = pat;
    run_q.push_back('{cycles: n, counts: exp_counts(pat, n)});
    issue_cmd(1'b1, 3'b000, n);
    wait_idle();
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_data"}, 64'(snn_data), 64'h0);
    chk({tag, "_ctrl"}, 64'(snn_ctrl), 64'(CTRL_IDLE));
    chk({tag, "_sync"}, 64'(snn_sync), 64'h0);
    chk({tag, "_exec"}, 64'(snn_execute), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'h0);
    chk({tag, "_cnt_valid"}, 64'(cnt_valid), 64'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk_reset_pins("reset");
    chk("reset_counts", 64'(spike_counts), 64'h0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'h1);

    // Back-to-back weight bytes.
    @(posedge clk); #1; ctrl_active = 0;
    issue_cmd(1'b0, SETUP_WEIGHTS, 3);
    send_byte(SETUP_WEIGHTS, 8'h11, 0);
    send_byte(SETUP_WEIGHTS, 8'h22, 0);
    send_byte(SETUP_WEIGHTS, 8'h33, 0);
    wait_idle();
    chk("b2b_ctrl_cycles", 64'(ctrl_active), 64'd3);
    chk("b2b_ctrl_after", 64'(snn_ctrl), 64'(CTRL_IDLE));

    // Same load with two idle cycles between bytes.
    ctrl_active = 0;
    issue_cmd(1'b0, SETUP_WEIGHTS, 3);
    send_byte(SETUP_WEIGHTS, 8'h11, 0);
    send_byte(SETUP_WEIGHTS, 8'h22, 2);
    send_byte(SETUP_WEIGHTS, 8'h33, 2);
    wait_idle();
    chk("gap_ctrl_cycles", 64'(ctrl_active), 64'd3);

    // Dead target: bytes consumed, pins silent.
    ctrl_active = 0;
    issue_cmd(1'b0, 3'b010, 2);
    send_byte(3'b010, 8'h5A, 0);
    send_byte(3'b010, 8'hA5, 0);
    wait_idle();
    chk("dead_tgt_ctrl_cycles", 64'(ctrl_active), 64'd0);

    // Runs: partial pattern, saturation, zero length.
    do_run(8'h05, 10);
    do_run(8'hFF, 300);
    do_run(8'h3C, 0);
    do_run(8'h81, 1);

    // LOAD of zero bytes: nothing on the pins, ready again next cycle.
    ctrl_active = 0;
    issue_cmd(1'b0, SETUP_THRESH, 0);
    @(negedge clk);
    chk("load0_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("load0_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    chk("load0_ctrl_cycles", 64'(ctrl_active), 64'd0);

    // Reset in the middle of a 4-byte batchnorm load.
    issue_cmd(1'b0, SETUP_BN, 4);
    send_byte(SETUP_BN, 8'hC1, 0);
    send_byte(SETUP_BN, 8'hC2, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_pins("midrst");
    chk("midrst_counts", 64'(spike_counts), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'h1);
    ctrl_active = 0;
    issue_cmd(1'b0, SETUP_THRESH, 1);
    send_byte(SETUP_THRESH, 8'hA5, 0);
    wait_idle();
    chk("midrst_reload_ctrl_cycles", 64'(ctrl_active), 64'd1);

    chk("pin_queue_drained", 64'(pin_q.size()), 64'd0);
    chk("run_queue_drained", 64'(run_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
